// File: rtl/brisc_pkg.sv
// Shared fetch-side types and constants for the brisc front end.
package brisc_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned WORLD_LEN        = 32;
    localparam int unsigned CACHE_LINE_LEN   = 128;
    localparam int unsigned LINE_WORDS       = CACHE_LINE_LEN / WORLD_LEN;
    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam int unsigned TAG_BITS         = XLEN - LINE_OFFSET_BITS;
    localparam int unsigned WORD_SEL_BITS    = $clog2(LINE_WORDS);

    localparam logic [XLEN-1:0] PC_BOOT   = 32'h0000_1000;
    localparam logic [XLEN-1:0] PC_EXCEPT = 32'h0000_2000;
    localparam logic [XLEN-1:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_t;

    function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
    endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Single-line instruction buffer: one tagged 128-bit line, combinational hit and word select.
module fetch_line_buf
    import brisc_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_fill_valid,
    input  logic [TAG_BITS-1:0]       i_fill_tag,
    input  logic [CACHE_LINE_LEN-1:0] i_fill_data,
    input  logic [TAG_BITS-1:0]       i_pc_tag,
    input  logic [WORD_SEL_BITS-1:0]  i_word_sel,
    output logic                      o_hit_c,
    output logic [WORLD_LEN-1:0]      o_word_c
);

    logic                      r_valid;
    logic [TAG_BITS-1:0]       r_tag;
    logic [CACHE_LINE_LEN-1:0] r_data;

    // Only the valid bit needs reset; tag/data are qualified by it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_fill_valid) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_valid) begin
            r_tag  <= i_fill_tag;
            r_data <= i_fill_data;
        end
    end

    assign o_hit_c  = r_valid && (r_tag == i_pc_tag);
    assign o_word_c = r_data[{i_word_sel, 5'b0} +: WORLD_LEN];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, IF/ID register and line-fill handshake around one line buffer.
module fetch_stage
    import brisc_pkg::*;
#(
    parameter logic [31:0] BOOT_PC   = PC_BOOT,
    parameter logic [31:0] EXCEPT_PC = PC_EXCEPT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    input  logic                      except_valid,
    output logic                      mem_req_valid,
    output logic [XLEN-1:0]           mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [CACHE_LINE_LEN-1:0] mem_resp_data,
    output logic                      instr_valid,
    output logic [XLEN-1:0]           instr,
    output logic [XLEN-1:0]           instr_pc
);

    fetch_state_e         r_state;
    logic [XLEN-1:0]      r_pc;
    ifid_t                r_ifid;
    logic                 r_req_valid;
    logic [XLEN-1:0]      r_req_addr;

    logic                 w_hit;
    logic [WORLD_LEN-1:0] w_word;
    logic                 w_fill;
    logic                 w_unused_c;

    // A fill lands only while a response is actually expected
    assign w_fill     = (r_state == WAIT) && mem_resp_valid;
    assign w_unused_c = ^redirect_pc[1:0];

    fetch_line_buf u_line_buf (
        .clk          (clk),
        .reset        (reset),
        .i_fill_valid (w_fill),
        .i_fill_tag   (r_req_addr[XLEN-1:LINE_OFFSET_BITS]),
        .i_fill_data  (mem_resp_data),
        .i_pc_tag     (r_pc[XLEN-1:LINE_OFFSET_BITS]),
        .i_word_sel   (r_pc[LINE_OFFSET_BITS-1:2]),
        .o_hit_c      (w_hit),
        .o_word_c     (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= BOOT_PC;
            r_state     <= REQ;
            r_ifid      <= '{valid: 1'b0, instr: NOP, pc: '0};
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            // PC / IF/ID priority: exception, redirect, stall, hit, bubble
            if (except_valid) begin
                r_pc   <= EXCEPT_PC;
                r_ifid <= '{valid: 1'b0, instr: NOP, pc: '0};
            end else if (redirect_valid) begin
                r_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
                r_ifid <= '{valid: 1'b0, instr: NOP, pc: '0};
            end else if (!stall) begin
                if (w_hit) begin
                    r_ifid <= '{valid: 1'b1, instr: w_word, pc: r_pc};
                    r_pc   <= r_pc + 32'd4;
                end else begin
                    r_ifid <= '{valid: 1'b0, instr: NOP, pc: r_pc};
                end
            end

            // Fill FSM; an in-flight request survives redirects and is re-checked on return to RUN
            case (r_state)
                RUN: begin
                    if (!except_valid && !redirect_valid && !w_hit) begin
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= line_addr(r_pc);
                    end
                end
                REQ: begin
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= line_addr(r_pc);
                    end else if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign instr_valid   = r_ifid.valid;
    assign instr         = r_ifid.instr;
    assign instr_pc      = r_ifid.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven check of fetch_stage: boot fill, stall, redirects, exception, reset mid-fill.
module tb_fetch_stage;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         except_valid;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .except_valid   (except_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         stall;
        logic         redir;
        logic [31:0]  redir_pc;
        logic         exc;
        logic         rdy;
        logic         rsp;
        logic [127:0] data;
        logic         e_iv;
        logic [31:0]  e_instr;
        logic [31:0]  e_ipc;
        logic         e_rv;
        logic [31:0]  e_ra;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic ex, input logic rdy, input logic rsp,
                                input logic [127:0] d, input logic iv, input logic [31:0] ins,
                                input logic [31:0] ipc, input logic rv, input logic [31:0] ra);
        vec_t v;
        v.stall = st; v.redir = rd; v.redir_pc = rpc; v.exc = ex; v.rdy = rdy; v.rsp = rsp;
        v.data = d; v.e_iv = iv; v.e_instr = ins; v.e_ipc = ipc; v.e_rv = rv; v.e_ra = ra;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic iv, input logic [31:0] ins,
                              input logic [31:0] ipc, input logic rv, input logic [31:0] ra);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
        check({tag, ".instr"}, instr, ins);
        check({tag, ".instr_pc"}, instr_pc, ipc);
        check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'(rv));
        if (rv) check({tag, ".mem_req_addr"}, mem_req_addr, ra);
    endtask

    task automatic clear_inputs();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; except_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    initial begin
        logic [127:0] line_1000;
        logic [127:0] line_1010;
        logic [127:0] line_3000;
        logic [127:0] junk;
        line_1000 = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        line_1010 = {32'h0000_1013, 32'h0000_1012, 32'h0000_1011, 32'h0000_1010};
        line_3000 = {32'h0000_3003, 32'h0000_3002, 32'h0000_3001, 32'h0000_3000};
        junk      = {4{32'hDEAD_BEEF}};

        //               st rd rpc          ex rdy rsp data       iv instr         ipc          rv ra
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        0, NOP_I,        32'h1000,    1, 32'h1000)); // boot request
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 0, '0,        0, NOP_I,        32'h1000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 1, line_1000, 0, NOP_I,        32'h1000,    0, 32'h0));    // fill
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'hA,        32'h1000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'hB,        32'h1004,    0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,       0, 0, 0, '0,        1, 32'hB,        32'h1004,    0, 32'h0));    // stall x3
        vecs.push_back(mk(1, 0, 32'h0,       0, 0, 0, '0,        1, 32'hB,        32'h1004,    0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,       0, 0, 0, '0,        1, 32'hB,        32'h1004,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'hC,        32'h1008,    0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h1006,    0, 0, 0, '0,        0, NOP_I,        32'h0,       0, 32'h0));    // back to 0x1004
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'hB,        32'h1004,    0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h100E,    0, 0, 0, '0,        0, NOP_I,        32'h0,       0, 32'h0));    // in-line redirect
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'hD,        32'h100C,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        0, NOP_I,        32'h1010,    1, 32'h1010)); // line-end miss
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        0, NOP_I,        32'h1010,    1, 32'h1010)); // held until ready
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 0, '0,        0, NOP_I,        32'h1010,    0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h3000,    0, 0, 0, '0,        0, NOP_I,        32'h0,       0, 32'h0));    // redirect in WAIT
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 1, line_1010, 0, NOP_I,        32'h3000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        0, NOP_I,        32'h3000,    1, 32'h3000)); // tag re-check
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 0, '0,        0, NOP_I,        32'h3000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 1, line_3000, 0, NOP_I,        32'h3000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'h3000,     32'h3000,    0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 1, junk,      1, 32'h3001,     32'h3004,    0, 32'h0));    // stray response
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 0, '0,        1, 32'h3002,     32'h3008,    0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h100E,    1, 0, 0, '0,        0, NOP_I,        32'h0,       0, 32'h0));    // exc+redir+stall
        vecs.push_back(mk(1, 0, 32'h0,       0, 0, 0, '0,        0, NOP_I,        32'h0,       1, 32'h2000));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 0, '0,        0, NOP_I,        32'h2000,    0, 32'h0));

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, NOP_I, 32'h0, 1'b0, 32'h0);

        reset = 1'b0;
        foreach (vecs[i]) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            except_valid   = vecs[i].exc;
            mem_req_ready  = vecs[i].rdy;
            mem_resp_valid = vecs[i].rsp;
            mem_resp_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check_outs($sformatf("row%0d", i), vecs[i].e_iv, vecs[i].e_instr,
                       vecs[i].e_ipc, vecs[i].e_rv, vecs[i].e_ra);
        end

        // Reset while WAITing for the 0x2000 fill, with a response arriving at the same edge
        clear_inputs();
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = junk;
        @(posedge clk);
        #1;
        check_outs("rst_wait", 1'b0, NOP_I, 32'h0, 1'b0, 32'h0);

        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rst_reissue", 1'b0, NOP_I, 32'h1000, 1'b1, 32'h1000);

        // Buffer must be invalid after reset: a late response outside WAIT is ignored
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_1000;
        @(posedge clk);
        #1;
        check_outs("rst_no_fill", 1'b0, NOP_I, 32'h1000, 1'b1, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter BOOT_PC, default PC_BOOT (0x00001000), PC loaded on reset.
REQ-002 SHALL have parameter EXCEPT_PC, default PC_EXCEPT (0x00002000), PC loaded on exception.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  decode cannot accept; hold the IF/ID register.
REQ-006 SHALL have port redirect_valid  in  1  taken branch or jump.
REQ-007 SHALL have port redirect_pc  in  32  branch or jump target.
REQ-008 SHALL have port except_valid  in  1  trap; fetch from EXCEPT_PC.
REQ-009 SHALL have port mem_req_valid  out  1  line-fill request.
REQ-010 SHALL have port mem_req_addr  out  32  line-aligned fill address.
REQ-011 SHALL have port mem_req_ready  in  1  memory accepts the request.
REQ-012 SHALL have port mem_resp_valid  in  1  fill data is valid.
REQ-013 SHALL have port mem_resp_data  in  128  fill line; word k is bits [32k+31:32k].
REQ-014 SHALL have port instr_valid  out  1  IF/ID register holds a real instruction.
REQ-015 SHALL have port instr  out  32  IF/ID instruction.
REQ-016 SHALL have port instr_pc  out  32  IF/ID instruction address.

Function
REQ-017 SHALL hold one line buffer: valid bit, 28-bit tag (addr[31:4]) and 128-bit data.
REQ-018 SHALL define hit as buffer valid and tag equal to pc[31:4]; the selected word is pc[3:2].
REQ-019 SHALL use FSM states RUN, REQ and WAIT: RUN to REQ on miss; REQ to WAIT on mem_req_valid&&mem_req_ready; WAIT to RUN on mem_resp_valid.
REQ-020 SHALL assert mem_req_valid only in REQ, with mem_req_addr = {pc[31:4],4'b0}; valid and address stay stable until accepted.
REQ-021 SHALL, on mem_resp_valid in WAIT, load the buffer with the response data and the tag of the requested address.
REQ-022 SHALL ignore mem_resp_valid outside WAIT.
REQ-023 SHALL apply this per-edge priority: except_valid > redirect_valid > stall > hit > bubble.
REQ-024 SHALL, on except_valid, set pc=EXCEPT_PC and load the IF/ID register with {0, NOP, 0}.
REQ-025 SHALL, on redirect_valid, set pc={redirect_pc[31:2],2'b00} and load the IF/ID register with {0, NOP, 0}.
REQ-026 SHALL, on stall, hold both pc and the IF/ID register.
REQ-027 SHALL, on hit, load the IF/ID register with {1, word, pc} and set pc=pc+4 (mod 2^32).
REQ-028 SHALL, in any other case, load the IF/ID register with {0, NOP, pc}.
REQ-029 SHALL leave an outstanding request or fill running when a redirect or exception arrives; the request is not dropped.
REQ-030 SHALL re-check the tag after such a fill and request the target line on mismatch.
REQ-031 SHALL give redirect latency of one bubble cycle, then the target instruction if the target line is buffered.
REQ-032 SHALL give miss latency of one cycle to REQ, then the memory handshake, then an instruction one cycle after the fill.

Reset
REQ-033 SHALL, on reset, set pc=BOOT_PC, state=REQ, buffer valid=0, instr_valid=0, instr=NOP, instr_pc=0 and mem_req_valid=0 in that cycle.
REQ-034 SHALL let reset override everything, including mid-WAIT; the memory side is reset by the same reset.

Structure
REQ-035 SHALL place in brisc_pkg: fetch_state_e {RUN, REQ, WAIT}, LINE_WORDS=CACHE_LINE_LEN/WORLD_LEN (4) and LINE_OFFSET_BITS=4.
REQ-036 SHALL implement the line buffer as sub-module fetch_line_buf (valid/tag/data, fill port, hit and word-select outputs).

Verification
REQ-037 SHALL cover boot: reset, then release -> request 0x1000; respond with 0xA,0xB,0xC,0xD -> instrs 0xA..0xD at pcs 0x1000..0x100C on consecutive cycles, then request 0x1010.
REQ-038 SHALL cover stall: stall=1 for 3 cycles while instr_pc=0x1004 -> outputs unchanged, no request; on release 0x1008 follows.
REQ-039 SHALL cover in-line redirect: redirect to 0x100E while at 0x1004 -> one bubble, then instr_pc=0x100C, no mem request.
REQ-040 SHALL cover exception with stall: except_valid and redirect_valid together with stall=1 -> bubble, then request 0x2000.
REQ-041 SHALL cover redirect during a fill: redirect to 0x3000 in WAIT for 0x1010 -> fill completes, then request 0x3000, first instr_pc=0x3000.
REQ-042 SHALL cover reset mid-WAIT: reset asserted -> instr_valid=0, then request 0x1000 re-issued.
